// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2
  } rsa_state_e;

  localparam logic CFG_SEL_E = 1'b0;
  localparam logic CFG_SEL_N = 1'b1;

  localparam int RSA_DEFAULT_N = 3233;
  localparam int RSA_DEFAULT_E = 17;

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Config/start/result bus of the modexp engine; master is the pipeline controller side.
interface rsa_modexp_engine_if #(
  parameter int WIDTH = 16
);
  logic             cfg_we;
  logic             cfg_sel;
  logic [WIDTH-1:0] cfg_data;
  logic             start;
  logic [WIDTH-1:0] msg;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output cfg_we, cfg_sel, cfg_data, start, msg,
    input  busy, done, err, result
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, start, msg,
    output busy, done, err, result
  );
endinterface

// File: rtl/rsa_modmul.sv
// Combinational (a*b) mod n on a full double-width product.
module rsa_modmul #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] prod;

  always_comb begin
    prod = PW'(a) * PW'(b);
    // n==0 is never used by the engine (caught as an error), but keep the divider defined
    if (n == '0) p = '0;
    else         p = WIDTH'(prod % PW'(n));
  end
endmodule

// File: rtl/rsa_modexp_engine.sv
// Right-to-left square-and-multiply msg^e mod n, one exponent bit per clock.
// Define RSA_MODEXP_CONST_TIME_EN to always run EXP_WIDTH steps regardless of e.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  rsa_modexp_engine_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, config writes accepted
  // LOAD  | reduce msg into base, acc=1, check modulus / zero exponent
  // STEP  | one square-and-multiply step per exponent bit

  rsa_state_e state, state_nxt;

  logic [WIDTH-1:0]     n_r, n_op, msg_r, base_r, acc_r;
  logic [WIDTH-1:0]     mul_a, mul_b, mul_p, sq_p, result_r;
  logic [EXP_WIDTH-1:0] e_r, exp_r;
  logic                 done_r, err_r;
  logic                 ld_op, step_en, fin, fin_err, fin_one, last_step;

`ifdef RSA_MODEXP_CONST_TIME_EN
  localparam int CNT_W = $clog2(EXP_WIDTH + 1);
  logic [CNT_W-1:0] cnt;
  assign last_step = (cnt == '0);
`else
  assign last_step = ((exp_r >> 1) == '0);
`endif

  // LOAD borrows the multiply path to compute msg*1 mod n
  assign mul_a = (state == LOAD) ? msg_r : acc_r;
  assign mul_b = (state == LOAD) ? WIDTH'(1) : base_r;

  rsa_modmul #(.WIDTH(WIDTH)) u_mul (.a(mul_a),  .b(mul_b),  .n(n_op), .p(mul_p));
  rsa_modmul #(.WIDTH(WIDTH)) u_sq  (.a(base_r), .b(base_r), .n(n_op), .p(sq_p));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_op     = 1'b0;
    step_en   = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_one   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          ld_op     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (n_op < WIDTH'(2)) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
`ifdef RSA_MODEXP_CONST_TIME_EN
          state_nxt = STEP;
`else
          if (exp_r == '0) begin
            fin       = 1'b1;
            fin_one   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = STEP;
          end
`endif
        end
      end
      STEP: begin
        step_en = 1'b1;
        if (last_step) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r      <= WIDTH'(RSA_DEFAULT_N);
      e_r      <= EXP_WIDTH'(RSA_DEFAULT_E);
      n_op     <= '0;
      msg_r    <= '0;
      exp_r    <= '0;
      base_r   <= '0;
      acc_r    <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= '0;
`ifdef RSA_MODEXP_CONST_TIME_EN
      cnt      <= '0;
`endif
    end else begin
      done_r <= fin;
      if (state == IDLE && bus.cfg_we) begin
        if (bus.cfg_sel == CFG_SEL_E) e_r <= EXP_WIDTH'(bus.cfg_data);
        else                          n_r <= bus.cfg_data;
      end
      // operands are snapshotted so a same-edge config write only affects later runs
      if (ld_op) begin
        msg_r <= bus.msg;
        exp_r <= e_r;
        n_op  <= n_r;
      end
      if (state == LOAD) begin
        base_r <= mul_p;
        acc_r  <= WIDTH'(1);
`ifdef RSA_MODEXP_CONST_TIME_EN
        cnt    <= CNT_W'(EXP_WIDTH - 1);
`endif
      end
      if (step_en) begin
        if (exp_r[0]) acc_r <= mul_p;
        base_r <= sq_p;
        exp_r  <= exp_r >> 1;
`ifdef RSA_MODEXP_CONST_TIME_EN
        cnt    <= cnt - 1'b1;
`endif
      end
      if (fin) begin
        err_r <= fin_err;
        if (fin_err)      result_r <= '0;
        else if (fin_one) result_r <= WIDTH'(1);
        else if (exp_r[0]) result_r <= mul_p;
        else              result_r <= acc_r;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed and randomised checks of rsa_modexp_engine at 16-bit and 32-bit widths.
module tb_rsa_modexp_engine;
  import rsa_pkg::*;

`ifdef RSA_MODEXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine_if #(.WIDTH(16)) if16 ();
  rsa_modexp_engine_if #(.WIDTH(32)) if32 ();

  rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave));
  rsa_modexp_engine #(.WIDTH(32), .EXP_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bitlen(input logic [31:0] e);
    int l = 0;
    for (int i = 0; i < 32; i++) if (e[i]) l = i + 1;
    return l;
  endfunction

  // left-to-right reference, independent of the engine's bit order
  function automatic logic [31:0] modpow(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r, bb;
    if (n < 2) return 32'd0;
    bb = 64'(b) % 64'(n);
    r  = 64'd1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % 64'(n);
      if (e[i]) r = (r * bb) % 64'(n);
    end
    return r[31:0];
  endfunction

  function automatic int exp_lat(input int l, input int ew);
    return CT ? 1 + ew : 1 + l;
  endfunction

  task automatic wr16(input logic sel, input logic [15:0] d);
    if16.cfg_we = 1'b1; if16.cfg_sel = sel; if16.cfg_data = d;
    @(posedge clk); #1;
    if16.cfg_we = 1'b0;
  endtask

  task automatic wr32(input logic sel, input logic [31:0] d);
    if32.cfg_we = 1'b1; if32.cfg_sel = sel; if32.cfg_data = d;
    @(posedge clk); #1;
    if32.cfg_we = 1'b0;
  endtask

  // start at edge k, return cycles from k to the done edge plus the outcome
  task automatic op16(input string tag, input logic [15:0] m, input bit disturb,
                      output int lat, output logic [15:0] res, output logic err);
    bit got = 1'b0;
    if16.msg = m; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0; if16.cfg_we = 1'b0;
    chk({tag, "_busy_rise"}, if16.busy, 1);
    lat = 0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 2) begin
        if16.start = 1'b1; if16.msg = 16'd7;
        if16.cfg_we = 1'b1; if16.cfg_sel = CFG_SEL_E; if16.cfg_data = 16'd5;
      end else if (disturb && lat == 3) begin
        if16.start = 1'b0; if16.cfg_we = 1'b0;
      end
      if (if16.done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_busy_fall"}, if16.busy, 0);
    res = if16.result; err = if16.err;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, if16.done, 0);
  endtask

  task automatic op32(input logic [31:0] m, output int lat, output logic [31:0] res,
                      output int ndone);
    if32.msg = m; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    lat = 0; ndone = 0;
    while (ndone == 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (if32.done) ndone++;
    end
    res = if32.result;
    repeat (3) begin
      @(posedge clk); #1;
      if (if32.done) ndone++;
    end
  endtask

  initial begin
    int          lat, nd;
    logic [15:0] r16;
    logic [31:0] r32, n32, e32, m32;
    logic        e16;
    bit          seen;

    if16.cfg_we = 0; if16.cfg_sel = 0; if16.cfg_data = 0; if16.start = 0; if16.msg = 0;
    if32.cfg_we = 0; if32.cfg_sel = 0; if32.cfg_data = 0; if32.start = 0; if32.msg = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", if16.busy, 0);
    chk("rst_done", if16.done, 0);
    chk("rst_err", if16.err, 0);
    chk("rst_result", if16.result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op16("m65", 16'd65, 1'b0, lat, r16, e16);
    chk("m65_result", r16, 2790);
    chk("m65_err", e16, 0);
    chk("m65_lat", lat, exp_lat(5, 16));

    wr16(CFG_SEL_E, 16'd2753);
    op16("dec", 16'd2790, 1'b0, lat, r16, e16);
    chk("dec_result", r16, 65);
    chk("dec_lat", lat, exp_lat(12, 16));

    wr16(CFG_SEL_E, 16'd0);
    op16("e0", 16'd123, 1'b0, lat, r16, e16);
    chk("e0_result", r16, 1);
    chk("e0_lat", lat, exp_lat(0, 16));

    wr16(CFG_SEL_N, 16'd1);
    op16("n1", 16'd123, 1'b0, lat, r16, e16);
    chk("n1_err", e16, 1);
    chk("n1_result", r16, 0);
    chk("n1_lat", lat, 1);

    wr16(CFG_SEL_N, 16'd3233);
    wr16(CFG_SEL_E, 16'd17);
    op16("big", 16'd3300, 1'b1, lat, r16, e16);
    chk("big_result", r16, 641);
    chk("big_err_clear", e16, 0);
    chk("big_lat", lat, exp_lat(5, 16));
    repeat (3) @(posedge clk);
    #1;
    chk("no_queue_busy", if16.busy, 0);
    op16("after_dist", 16'd65, 1'b0, lat, r16, e16);
    chk("after_dist_result", r16, 2790);
    chk("after_dist_lat", lat, exp_lat(5, 16));

    // same-edge e write and start: this run uses e=17, the next uses e=5
    if16.cfg_we = 1'b1; if16.cfg_sel = CFG_SEL_E; if16.cfg_data = 16'd5;
    op16("same", 16'd65, 1'b0, lat, r16, e16);
    chk("same_result", r16, 2790);
    op16("new_e", 16'd2, 1'b0, lat, r16, e16);
    chk("new_e_result", r16, 32);
    chk("new_e_lat", lat, exp_lat(3, 16));

    // abort in the third STEP cycle with non-default config loaded
    wr16(CFG_SEL_E, 16'd2753);
    wr16(CFG_SEL_N, 16'd1000);
    if16.msg = 16'd65; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_pre", if16.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", if16.busy, 0);
    chk("abort_result", if16.result, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if16.done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    op16("post_rst", 16'd65, 1'b0, lat, r16, e16);
    chk("post_rst_result", r16, 2790);
    chk("post_rst_lat", lat, exp_lat(5, 16));

    // 32-bit sweep; defaults there are also n=3233, e=17
    op32(32'd65, lat, r32, nd);
    chk("w32_default", r32, 2790);
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin n32 = 32'hFFFF_FFFB; e32 = 32'hFFFF_FFFF; m32 = 32'hFFFF_FFFE; end
        1: begin n32 = 32'd2;         e32 = 32'd9;         m32 = 32'd3;         end
        2: begin n32 = 32'h8000_0001; e32 = 32'd1;         m32 = 32'hFFFF_0000; end
        default: begin
          n32 = $urandom | 32'h2;
          e32 = $urandom >> $urandom_range(0, 31);
          m32 = $urandom;
        end
      endcase
      wr32(CFG_SEL_N, n32);
      wr32(CFG_SEL_E, e32);
      op32(m32, lat, r32, nd);
      chk($sformatf("sweep%0d_result", i), r32, modpow(m32, e32, n32));
      chk($sformatf("sweep%0d_lat", i), lat, exp_lat(bitlen(e32), 32));
      chk($sformatf("sweep%0d_ndone", i), nd, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
